// File: rtl/param_tape_if.sv
// Command/status bundle for param_tape: the command fields plus the tape status outputs.
// The master drives commands; the slave (the tape) returns availability, pointer, symbol and error.
interface param_tape_if #(
  parameter int unsigned SYM_W  = 4,
  parameter int unsigned ADDR_W = 7
);
  logic              cmd_valid;
  logic [2:0]        cmd_op;
  logic              cmd_dir;
  logic [ADDR_W-1:0] cmd_count;
  logic [SYM_W-1:0]  cmd_data;
  logic              available;
  logic [SYM_W-1:0]  tape_symbol;
  logic [ADDR_W-1:0] tape_address;
  logic              tape_error;

  modport master (
    output cmd_valid, cmd_op, cmd_dir, cmd_count, cmd_data,
    input  available, tape_symbol, tape_address, tape_error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_dir, cmd_count, cmd_data,
    output available, tape_symbol, tape_address, tape_error
  );
endinterface

// File: rtl/param_tape.sv
// Pointer-addressed symbol tape: single-cycle cell edits, multi-cycle pointer moves,
// rollback to cell 0 and a one-cell-per-cycle clear sweep.
module param_tape #(
  parameter int unsigned SYM_W  = 4,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic         working_clock,
  input  logic         reset,
  param_tape_if.slave  bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_SET    = 3'd1,
    OP_INC    = 3'd2,
    OP_DEC    = 3'd3,
    OP_MOVE   = 3'd4,
    OP_ROLL   = 3'd5,
    OP_DELETE = 3'd6,
    OP_CLEAR  = 3'd7
  } op_e;

  typedef enum logic [1:0] {INIT, WAIT, MOVE, ROLL} state_e;

  state_e            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] steps_left;
  logic              move_dir;
  logic              available_q;
  logic              error_q;

  logic [SYM_W-1:0]  mem [DEPTH];

  logic              accept_c;
  logic              move_ok_c;
  logic [CNT_W-1:0]  ptr_ext_c;
  logic [CNT_W-1:0]  cnt_ext_c;
  logic [SYM_W-1:0]  cur_sym_c;
  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [SYM_W-1:0]  mem_wdata_c;

  assign accept_c  = available_q & bus.cmd_valid;
  assign cur_sym_c = mem[ptr];
  assign ptr_ext_c = CNT_W'(ptr);
  assign cnt_ext_c = CNT_W'(bus.cmd_count);

  // Target range check done one bit wider so ptr+count cannot wrap
  assign move_ok_c = bus.cmd_dir ? ((ptr_ext_c + cnt_ext_c) <= CNT_W'(DEPTH - 1))
                                 : (cnt_ext_c <= ptr_ext_c);

  // Cell write port: clear sweep in INIT, single-cycle edits in WAIT
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = ptr;
    mem_wdata_c = '0;
    if (state == INIT) begin
      mem_we_c    = 1'b1;
      mem_waddr_c = clr_addr;
    end else if (state == WAIT && accept_c) begin
      case (op_e'(bus.cmd_op))
        OP_SET:    begin mem_we_c = 1'b1; mem_wdata_c = bus.cmd_data;            end
        OP_INC:    begin mem_we_c = 1'b1; mem_wdata_c = cur_sym_c + SYM_W'(1);   end
        OP_DEC:    begin mem_we_c = 1'b1; mem_wdata_c = cur_sym_c - SYM_W'(1);   end
        OP_DELETE: begin mem_we_c = 1'b1; mem_wdata_c = '0;                      end
        default:   mem_we_c = 1'b0;
      endcase
    end
  end

  always_ff @(posedge working_clock) begin
    if (mem_we_c && !reset) begin
      mem[mem_waddr_c] <= mem_wdata_c;
    end
  end

  always_ff @(posedge working_clock) begin
    if (reset) begin
      state       <= INIT;
      ptr         <= '0;
      clr_addr    <= '0;
      steps_left  <= '0;
      move_dir    <= 1'b0;
      available_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      error_q <= 1'b0;
      case (state)
        INIT: begin
          ptr <= '0;
          if (clr_addr == ADDR_W'(DEPTH - 1)) begin
            state       <= WAIT;
            available_q <= 1'b1;
            clr_addr    <= '0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
        end
        WAIT: begin
          if (accept_c) begin
            case (op_e'(bus.cmd_op))
              OP_MOVE: begin
                if (bus.cmd_count != '0) begin
                  if (move_ok_c) begin
                    state       <= MOVE;
                    available_q <= 1'b0;
                    steps_left  <= bus.cmd_count;
                    move_dir    <= bus.cmd_dir;
                  end else begin
                    error_q <= 1'b1;
                  end
                end
              end
              OP_ROLL: begin
                if (ptr != '0) begin
                  state       <= ROLL;
                  available_q <= 1'b0;
                end
              end
              OP_CLEAR: begin
                state       <= INIT;
                available_q <= 1'b0;
                ptr         <= '0;
                clr_addr    <= '0;
              end
              default: ;
            endcase
          end
        end
        MOVE: begin
          ptr        <= move_dir ? (ptr + ADDR_W'(1)) : (ptr - ADDR_W'(1));
          steps_left <= steps_left - ADDR_W'(1);
          if (steps_left == ADDR_W'(1)) begin
            state       <= WAIT;
            available_q <= 1'b1;
          end
        end
        ROLL: begin
          ptr <= ptr - ADDR_W'(1);
          if (ptr == ADDR_W'(1)) begin
            state       <= WAIT;
            available_q <= 1'b1;
          end
        end
        default: begin
          state       <= INIT;
          ptr         <= '0;
          clr_addr    <= '0;
          available_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.available    = available_q;
  assign bus.tape_symbol  = cur_sym_c;
  assign bus.tape_address = ptr;
  assign bus.tape_error   = error_q;

endmodule

// File: tb/tb_param_tape.sv
// Directed bench for param_tape: reset sweep, cell edits, moves, rollback,
// range rejection, clear-all and reset during a move.
module tb_param_tape;

  localparam int unsigned SYM_W  = 4;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ADDR_W = 7;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_SET    = 3'd1;
  localparam logic [2:0] OP_INC    = 3'd2;
  localparam logic [2:0] OP_DEC    = 3'd3;
  localparam logic [2:0] OP_MOVE   = 3'd4;
  localparam logic [2:0] OP_ROLL   = 3'd5;
  localparam logic [2:0] OP_DELETE = 3'd6;
  localparam logic [2:0] OP_CLEAR  = 3'd7;

  logic working_clock = 1'b0;
  logic reset         = 1'b1;
  int   errors        = 0;
  int   checks        = 0;

  param_tape_if #(.SYM_W(SYM_W), .ADDR_W(ADDR_W)) io ();

  param_tape #(.SYM_W(SYM_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .working_clock (working_clock),
    .reset         (reset),
    .bus           (io.slave)
  );

  always #5 working_clock = ~working_clock;

  task automatic tick();
    @(posedge working_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one edge
  task automatic issue(input logic [2:0] op, input logic dir, input int cnt, input logic [3:0] data);
    io.cmd_valid = 1'b1;
    io.cmd_op    = op;
    io.cmd_dir   = dir;
    io.cmd_count = ADDR_W'(cnt);
    io.cmd_data  = data;
    tick();
    io.cmd_valid = 1'b0;
    io.cmd_op    = OP_NOP;
  endtask

  task automatic wait_avail(output int n);
    n = -1;
    for (int i = 1; i <= int'(DEPTH) + 20; i++) begin
      tick();
      if (io.available === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Walk the pointer across every cell counting nonzero symbols, then roll back
  task automatic sweep_check(input string tag);
    int nz;
    int n;
    nz = (io.tape_symbol !== 4'h0) ? 1 : 0;
    issue(OP_MOVE, 1'b1, DEPTH - 1, 4'h0);
    for (int i = 1; i < int'(DEPTH); i++) begin
      tick();
      if (io.tape_symbol !== 4'h0) nz++;
    end
    chk({tag, "_nonzero_cells"}, nz, 0);
    chk({tag, "_end_addr"}, io.tape_address, DEPTH - 1);
    chk({tag, "_end_avail"}, io.available, 1);
    issue(OP_ROLL, 1'b0, 0, 4'h0);
    wait_avail(n);
    chk({tag, "_roll_cycles"}, n, DEPTH - 1);
    chk({tag, "_roll_addr"}, io.tape_address, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    io.cmd_valid = 1'b0;
    io.cmd_op    = OP_NOP;
    io.cmd_dir   = 1'b0;
    io.cmd_count = '0;
    io.cmd_data  = '0;

    // Reset and initial sweep
    reset = 1'b1;
    tick();
    tick();
    chk("rst_avail", io.available, 0);
    chk("rst_addr", io.tape_address, 0);
    chk("rst_err", io.tape_error, 0);
    reset = 1'b0;
    wait_avail(n);
    chk("init_cycles", n, DEPTH);
    chk("init_addr", io.tape_address, 0);
    sweep_check("init");

    // Back-to-back single-cycle edits at cell 0
    issue(OP_SET, 1'b0, 0, 4'hF);
    chk("set_f", io.tape_symbol, 4'hF);
    chk("set_avail", io.available, 1);
    issue(OP_INC, 1'b0, 0, 4'h0);
    chk("inc_wrap", io.tape_symbol, 4'h0);
    chk("inc_avail", io.available, 1);
    issue(OP_DEC, 1'b0, 0, 4'h0);
    chk("dec_wrap", io.tape_symbol, 4'hF);
    chk("dec_avail", io.available, 1);
    io.cmd_valid = 1'b0;
    io.cmd_op    = OP_SET;
    io.cmd_data  = 4'h3;
    tick();
    io.cmd_op    = OP_NOP;
    chk("invalid_ignored", io.tape_symbol, 4'hF);
    issue(OP_SET, 1'b0, 0, 4'h5);
    chk("set_5", io.tape_symbol, 4'h5);
    issue(OP_INC, 1'b0, 0, 4'h0);
    chk("inc_6", io.tape_symbol, 4'h6);
    issue(OP_DELETE, 1'b0, 0, 4'h0);
    chk("delete", io.tape_symbol, 4'h0);
    issue(OP_DEC, 1'b0, 0, 4'h0);
    chk("dec_from_0", io.tape_symbol, 4'hF);

    // MOVE with zero count is a no-op
    issue(OP_MOVE, 1'b1, 0, 4'h0);
    chk("move0_avail", io.available, 1);
    chk("move0_err", io.tape_error, 0);
    chk("move0_addr", io.tape_address, 0);

    // MOVE right 5 then rollback
    issue(OP_MOVE, 1'b1, 5, 4'h0);
    chk("move5_busy", io.available, 0);
    wait_avail(n);
    chk("move5_cycles", n, 5);
    chk("move5_addr", io.tape_address, 5);
    chk("move5_sym", io.tape_symbol, 4'h0);
    issue(OP_SET, 1'b0, 0, 4'hA);
    chk("set_a_at5", io.tape_symbol, 4'hA);
    issue(OP_ROLL, 1'b0, 0, 4'h0);
    wait_avail(n);
    chk("roll5_cycles", n, 5);
    chk("roll5_addr", io.tape_address, 0);
    chk("roll5_cell0_kept", io.tape_symbol, 4'hF);
    issue(OP_ROLL, 1'b0, 0, 4'h0);
    chk("roll0_avail", io.available, 1);
    chk("roll0_addr", io.tape_address, 0);

    // Right-edge rejection and last legal cell
    issue(OP_MOVE, 1'b1, DEPTH - 2, 4'h0);
    wait_avail(n);
    chk("move126_addr", io.tape_address, DEPTH - 2);
    issue(OP_MOVE, 1'b1, 2, 4'h0);
    chk("rej_right_err", io.tape_error, 1);
    chk("rej_right_addr", io.tape_address, DEPTH - 2);
    chk("rej_right_avail", io.available, 1);
    tick();
    chk("rej_right_err_clr", io.tape_error, 0);
    chk("rej_right_addr_hold", io.tape_address, DEPTH - 2);
    issue(OP_MOVE, 1'b1, 1, 4'h0);
    wait_avail(n);
    chk("move_last_cycles", n, 1);
    chk("move_last_addr", io.tape_address, DEPTH - 1);
    issue(OP_MOVE, 1'b0, 2, 4'h0);
    wait_avail(n);
    chk("move_left_addr", io.tape_address, DEPTH - 3);
    issue(OP_ROLL, 1'b0, 0, 4'h0);
    wait_avail(n);
    chk("roll125_cycles", n, DEPTH - 3);

    // Left-edge rejection
    issue(OP_MOVE, 1'b0, 1, 4'h0);
    chk("rej_left_err", io.tape_error, 1);
    chk("rej_left_addr", io.tape_address, 0);
    tick();
    chk("rej_left_err_clr", io.tape_error, 0);

    // CLEAR_ALL wipes cells 0 and 5
    issue(OP_CLEAR, 1'b0, 0, 4'h0);
    chk("clear_busy", io.available, 0);
    wait_avail(n);
    chk("clear_cycles", n, DEPTH);
    sweep_check("clear");

    // Reset during step 3 of a 6-step move
    issue(OP_SET, 1'b0, 0, 4'h9);
    issue(OP_MOVE, 1'b1, 3, 4'h0);
    wait_avail(n);
    issue(OP_SET, 1'b0, 0, 4'h7);
    chk("pre_rst_sym", io.tape_symbol, 4'h7);
    issue(OP_MOVE, 1'b1, 6, 4'h0);
    tick();
    tick();
    chk("mid_move_addr", io.tape_address, 5);
    reset = 1'b1;
    tick();
    chk("midrst_addr", io.tape_address, 0);
    chk("midrst_avail", io.available, 0);
    chk("midrst_err", io.tape_error, 0);
    reset = 1'b0;
    wait_avail(n);
    chk("midrst_init_cycles", n, DEPTH);
    sweep_check("midrst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/param_tape.md
PARAM_TAPE -- requirements
Module: param_tape

Interface
REQ-001 SHALL have parameters (name, default, meaning): SYM_W, 4, symbol width in bits.
REQ-002 SHALL have parameter DEPTH, 128, number of tape cells (>=2).
REQ-003 SHALL have parameter ADDR_W, clog2(DEPTH), pointer and count width.
REQ-004 SHALL have port working_clock  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  in  1  command present.
REQ-007 SHALL have port cmd_op  in  3  opcode: 0 NOP, 1 SET, 2 INC, 3 DEC, 4 MOVE, 5 ROLLBACK, 6 DELETE, 7 CLEAR_ALL.
REQ-008 SHALL have port cmd_dir  in  1  MOVE direction: 1 right (+), 0 left (-).
REQ-009 SHALL have port cmd_count  in  ADDR_W  MOVE step count.
REQ-010 SHALL have port cmd_data  in  SYM_W  SET value.
REQ-011 SHALL have port available  out  1  registered; high means a command is accepted this cycle.
REQ-012 SHALL have port tape_symbol  out  SYM_W  cell at current pointer, combinational read.
REQ-013 SHALL have port tape_address  out  ADDR_W  current pointer, registered.
REQ-014 SHALL have port tape_error  out  1  one-cycle pulse on a rejected command.

Function
REQ-015 SHALL store DEPTH cells of SYM_W bits, addressed by a pointer; no data shifting.
REQ-016 SHALL implement states INIT, WAIT, MOVE, ROLL.
REQ-017 SHALL accept a command only at an edge where available=1 and cmd_valid=1; otherwise inputs are ignored.
REQ-018 SHALL handle SET, INC, DEC, DELETE in one cycle: cell updated at the accepting edge, state stays WAIT, available stays 1, so commands can be issued back-to-back.
REQ-019 SHALL have SET write cmd_data; INC/DEC add/subtract 1 modulo 2^SYM_W (wrap at max/0); DELETE write 0.
REQ-020 SHALL, on MOVE with cmd_count=N>=1 and target in [0, DEPTH-1], enter MOVE with available=0, step the pointer one cell per edge, and return to WAIT with available=1 at the Nth step edge.
REQ-021 SHALL treat MOVE with N=0 as NOP (available stays 1, no error).
REQ-022 SHALL reject MOVE whose target is <0 or >DEPTH-1: pointer unchanged, stay in WAIT, tape_error=1 for the following cycle.
REQ-023 SHALL, on ROLLBACK with pointer P>0, enter ROLL, decrement the pointer one per edge, and reach WAIT with pointer 0 after P edges; with P=0, act as NOP.
REQ-024 SHALL, on CLEAR_ALL, enter INIT.
REQ-025 SHALL, in INIT, zero one cell per edge from address 0 to DEPTH-1 (DEPTH cycles), hold the pointer at 0 and available at 0, then enter WAIT with available=1.
REQ-026 SHALL keep cell contents unchanged during MOVE/ROLL.
REQ-027 SHALL clear tape_error in every cycle other than the one after a rejection.
REQ-028 SHALL map an undefined state to INIT.

Reset
REQ-029 SHALL, when reset=1 at an edge (any state, including mid-MOVE/ROLL/INIT): state INIT, pointer 0, available 0, tape_error 0, clear sweep restarts at address 0.
REQ-030 SHALL give reset priority over any command presented in the same cycle.

Verification
REQ-031 SHALL cover: reset, then wait -> available=0 for DEPTH cycles, then 1; every cell reads 0.
REQ-032 SHALL cover: SET 4'hF, then INC -> symbol 0; then DEC -> 4'hF; back-to-back, available stays 1.
REQ-033 SHALL cover: MOVE right N=5 from 0 -> available low 5 cycles, tape_address=5; then ROLLBACK -> 5 cycles, address 0.
REQ-034 SHALL cover: at address DEPTH-2, MOVE right N=2 -> address unchanged, tape_error pulse 1 cycle; MOVE left from 0 -> same.
REQ-035 SHALL cover: reset asserted mid-MOVE (step 3 of 6) -> next cycle address 0, available 0, INIT sweep restarts; values set before reset are read back as 0.
